dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Parametrised data-memory controller for the MIPS pipeline MEM stage, replacing the fixed 256-word memory. It supports byte/halfword/word accesses with byte-lane merging on stores and sign/zero extension on loads. It flags misaligned and out-of-window accesses, and registers read data with a fixed 1-cycle latency. After reset, an internal sequencer zero-fills the array, so the storage does not need a reset fan-out to every word.

## Interface
- DATA_W, 32, word width in bits; must be 32.
- DEPTH, 256, number of words; power of two, minimum 4.
- BASE_ADDR, 32'h0000_0400, byte address of word 0; must be DEPTH*4-aligned.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  access request from the MEM stage.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_signed  in  1  load sign-extends when 1 and zero-extends when 0; ignored on stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified: the byte is in [7:0] and the half is in [15:0].
- rsp_valid  out  1  response for the request accepted last cycle.
- rsp_rdata  out  32  extended load data; holds its last value otherwise.
- rsp_err  out  1  the accepted request was misaligned, out of window, or had size 3.
- init_busy  out  1  zero-fill in progress.

## Operation
- **State machine:** INIT → IDLE.
  - Asynchronous reset forces INIT with fill counter = 0.
  - In INIT, one word per cycle is written with 0 at index counter, and the counter increments.
  - When the counter reaches DEPTH-1 and that write completes, the FSM moves to IDLE.
  - Reset asserted mid-fill restarts the fill from 0.
- **req_ready:** 1 only in IDLE. Requests presented in INIT are not accepted, and the requester must hold them.
- **Address decode:**
  - off = req_addr − BASE_ADDR, computed as a 32-bit unsigned difference.
  - The access is in window when req_addr ≥ BASE_ADDR and off < DEPTH*4.
  - Word index = off[log2(DEPTH)+1:2] and lane = off[1:0].
- **Alignment:** a half access requires lane[0] = 0; a word access requires lane = 0. Byte accesses are always aligned.
- **Error handling:** any error sets rsp_err = 1, blocks the write, and leaves rsp_rdata unchanged.
- **Store:** a read-modify-free byte-enable write.
  - Byte: wdata[7:0] is written to lane byte lane.
  - Half: wdata[15:0] is written to bytes lane and lane+1.
  - Word: the full word is written.
  - Little-endian: byte 0 = bits [7:0].
- **Load:** the addressed word is read and the selected byte or half is shifted down, then sign- or zero-extended to 32 bits.
- Every accepted request (load or store) produces exactly one rsp_valid pulse. On a store response rsp_rdata is unchanged.
- Back-to-back requests are accepted every cycle in IDLE. A load following a store to the same word in the next cycle returns the new data, because the array is written on the store's edge.

## Timing
- **Reset values:** req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, init_busy = 1, fill counter = 0.
- **Fill duration:** exactly DEPTH cycles after rst_n deasserts. init_busy falls and req_ready rises on the same edge.
- **Latency:** a request accepted at edge N has rsp_valid, rsp_rdata and rsp_err valid after edge N+1, for one cycle only.
- **No backpressure on responses:** the consumer must take the response in its valid cycle.
- **Write commit:** the store commits at acceptance edge N.

## Structure
- **Shared package dmem_pkg:**
  - size encoding constants SZ_BYTE, SZ_HALF, SZ_WORD.
  - FSM state enum {ST_INIT, ST_IDLE}.
- **Sub-module dmem_lane_align (combinational):**
  - from req_size and lane, generates the 4-bit byte-enable and the shifted store data;
  - from the read word, lane, size and signed, generates the extended load data.
- **Top-level contents:** decode, FSM, array and output registers.

## Test plan
- **Reset fill:** deassert rst_n, DEPTH=256.
  - init_busy is high for 256 cycles and req_ready is 0 throughout.
  - A subsequent load from 0x400 returns 0.
- **Byte/half merge:**
  - Store word 0x11223344 at 0x404.
  - Store byte 0xAA at 0x405.
  - Store half 0xBBCC at 0x406.
  - Load word at 0x404 returns 0xBBCCAA44.
- **Extension:** with 0x8000_00F0 at 0x408:
  - lb 0x408 returns 0xFFFFFFF0;
  - lbu 0x408 returns 0x000000F0;
  - lh 0x40A returns 0xFFFF8000.
- **Errors:**
  - Word load at 0x402 gives rsp_err = 1.
  - Store at 0x3FC and store at 0x800 both give rsp_err = 1, and memory is unchanged on readback.
  - size = 3 gives rsp_err = 1.
- **Throughput:** alternate store and load to the same word on consecutive cycles.
  - One rsp_valid occurs per cycle.
  - Each load returns the immediately preceding store's data.
- **Reset mid-fill:** assert rst_n low at fill cycle 100, then release.
  - The fill restarts and runs a full 256 cycles.
  - Memory that was written before the reset reads back 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size encodings and FSM states for the data-memory controller
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - store byte-enable/data steering and load byte/half extraction with extension
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lane,
  input  logic        ld_signed,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Replicating the store data lets the byte enables alone pick the lanes.
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = st_data;
    case (st_size)
      SZ_BYTE: begin
        st_be    = 4'b0001 << st_lane;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_be    = 4'b0011 << st_lane;
        st_wdata = {2{st_data[15:0]}};
      end
      SZ_WORD: st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  always_comb begin
    ld_byte = ld_word[7:0];
    case (ld_lane)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];

    ld_data = ld_word;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - MEM-stage data memory: decode, zero-fill FSM, byte-lane array, 1-cycle registered response
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_busy
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] WIN_BYTES = 32'(DEPTH * 4);

  state_t            state, state_next;
  logic [AW-1:0]     fill_cnt, fill_cnt_next;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [31:0]       off;
  logic [AW-1:0]     idx;
  logic [1:0]        lane;
  logic              in_window, misaligned, req_err, accept, wr_en;

  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wdata;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] ld_data;

  logic              p_valid, p_load, p_err, p_signed;
  logic [1:0]        p_size, p_lane;

  // The >= test also rejects addresses below the base that wrap into range.
  assign off       = req_addr - BASE_ADDR;
  assign in_window = (req_addr >= BASE_ADDR) && (off < WIN_BYTES);
  assign idx       = off[AW+1:2];
  assign lane      = off[1:0];

  assign misaligned = ((req_size == SZ_HALF) && lane[0]) ||
                      ((req_size == SZ_WORD) && (lane != 2'd0));
  assign req_err    = !in_window || misaligned || (req_size == 2'd3);
  assign accept     = req_valid && req_ready;
  assign wr_en      = accept && req_we && !req_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      fill_cnt <= '0;
    end else begin
      state    <= state_next;
      fill_cnt <= fill_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    fill_cnt_next = fill_cnt;
    req_ready     = 1'b0;
    init_busy     = 1'b0;
    case (state)
      ST_INIT: begin
        init_busy     = 1'b1;
        fill_cnt_next = fill_cnt + 1'b1;
        if (fill_cnt == AW'(DEPTH - 1)) state_next = ST_IDLE;
      end
      ST_IDLE: req_ready = 1'b1;
      default: state_next = ST_INIT;
    endcase
  end

  dmem_lane_align u_align (
    .st_size   (req_size),
    .st_lane   (lane),
    .st_data   (req_wdata),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_word   (rd_word),
    .ld_size   (p_size),
    .ld_lane   (p_lane),
    .ld_signed (p_signed),
    .ld_data   (ld_data)
  );

  // Array has no reset; the fill sequencer clears it word by word instead.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[fill_cnt] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[idx][8*b +: 8] <= st_wdata[8*b +: 8];
      end
    end
    rd_word <= mem[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid   <= 1'b0;
      p_load    <= 1'b0;
      p_err     <= 1'b0;
      p_size    <= SZ_BYTE;
      p_lane    <= 2'd0;
      p_signed  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      p_valid <= accept;
      p_load  <= accept && !req_we;
      p_err   <= accept && req_err;
      if (accept) begin
        p_size   <= req_size;
        p_lane   <= lane;
        p_signed <= req_signed;
      end
      rsp_valid <= p_valid;
      rsp_err   <= p_err;
      if (p_load && !p_err) rsp_rdata <= ld_data;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl against a byte-addressed reference model
module tb_dmem_ctrl;

  localparam int          DEPTH  = 256;
  localparam logic [31:0] BASE   = 32'h0000_0400;
  localparam int          NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, init_busy;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  dmem_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .init_busy  (init_busy)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
    logic        has_tab;
    logic        tab_err;
    logic        tab_chk;
    logic [31:0] tab_rd;
  } exp_t;

  logic [7:0]  mb [NBYTES];
  logic [31:0] last_rdata;
  exp_t        expq [$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t bubble();
    exp_t e;
    e.valid = 1'b0; e.err = 1'b0; e.rdata = last_rdata;
    e.has_tab = 1'b0; e.tab_err = 1'b0; e.tab_chk = 1'b0; e.tab_rd = '0;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
    last_rdata = '0;
    expq.delete();
    expq.push_back(bubble());
    expq.push_back(bubble());
  endtask

  // One cycle: check the response due now, then present the next request.
  task automatic step(input logic v, input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic has_tab, input logic tab_err, input logic tab_chk,
                      input logic [31:0] tab_rd);
    exp_t        e, f;
    logic        acc, err;
    logic [31:0] off, val;
    int          n;
    f = expq.pop_front();
    chk("rsp_valid", rsp_valid, f.valid);
    chk("rsp_rdata", rsp_rdata, f.rdata);
    chk("rsp_err", rsp_err, f.valid ? f.err : 1'b0);
    if (f.has_tab) begin
      chk("vec_err", rsp_err, f.tab_err);
      if (f.tab_chk) chk("vec_rdata", rsp_rdata, f.tab_rd);
    end

    req_valid = v; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    acc = v && (req_ready === 1'b1);
    if (has_tab) chk("vec_accepted", acc, 1'b1);

    e = bubble();
    e.valid   = acc;
    e.has_tab = has_tab && acc;
    e.tab_err = tab_err;
    e.tab_chk = tab_chk;
    e.tab_rd  = tab_rd;
    if (acc) begin
      off = addr - BASE;
      n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      err = (size == 2'd3) || (addr < BASE) || (off >= 32'(NBYTES)) || ((addr % 32'(n)) != 0);
      e.err = err;
      if (!err) begin
        if (we) begin
          for (int i = 0; i < n; i++) mb[off + 32'(i)] = wdata[8*i +: 8];
        end else begin
          val = '0;
          for (int i = 0; i < n; i++) val[8*i +: 8] = mb[off + 32'(i)];
          if (sgn && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8*n)) - 32'd1);
          last_rdata = val;
        end
      end
    end
    e.rdata = last_rdata;
    expq.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_init_busy", init_busy, 1'b1);
  endtask

  // Releases reset on a falling edge and counts rising edges until init_busy drops.
  task automatic wait_fill(input int limit, output int cycles);
    cycles = 0;
    rst_n = 1'b1;
    while (cycles < limit) begin
      @(posedge clk);
      #1;
      cycles++;
      if (!init_busy) break;
      chk("ready_during_fill", req_ready, 1'b0);
    end
    @(negedge clk);
  endtask

  vec_t tab [18];
  int   fill_cycles;
  logic [31:0] d;

  initial begin
    tab[0]  = '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0,        1'b0, 1'b1, 32'h0};
    tab[1]  = '{1'b1, 2'd2, 1'b0, 32'h404, 32'h11223344, 1'b0, 1'b0, 32'h0};
    tab[2]  = '{1'b1, 2'd0, 1'b0, 32'h405, 32'h000000AA, 1'b0, 1'b0, 32'h0};
    tab[3]  = '{1'b1, 2'd1, 1'b0, 32'h406, 32'h0000BBCC, 1'b0, 1'b0, 32'h0};
    tab[4]  = '{1'b0, 2'd2, 1'b0, 32'h404, 32'h0,        1'b0, 1'b1, 32'hBBCCAA44};
    tab[5]  = '{1'b1, 2'd2, 1'b0, 32'h408, 32'h800000F0, 1'b0, 1'b0, 32'h0};
    tab[6]  = '{1'b0, 2'd0, 1'b1, 32'h408, 32'h0,        1'b0, 1'b1, 32'hFFFFFFF0};
    tab[7]  = '{1'b0, 2'd0, 1'b0, 32'h408, 32'h0,        1'b0, 1'b1, 32'h000000F0};
    tab[8]  = '{1'b0, 2'd1, 1'b1, 32'h40A, 32'h0,        1'b0, 1'b1, 32'hFFFF8000};
    tab[9]  = '{1'b0, 2'd2, 1'b0, 32'h402, 32'h0,        1'b1, 1'b0, 32'h0};
    tab[10] = '{1'b1, 2'd2, 1'b0, 32'h3FC, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    tab[11] = '{1'b1, 2'd2, 1'b0, 32'h800, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0};
    tab[12] = '{1'b0, 2'd3, 1'b0, 32'h404, 32'h0,        1'b1, 1'b0, 32'h0};
    tab[13] = '{1'b0, 2'd2, 1'b0, 32'h404, 32'h0,        1'b0, 1'b1, 32'hBBCCAA44};
    tab[14] = '{1'b0, 2'd2, 1'b0, 32'h7FC, 32'h0,        1'b0, 1'b1, 32'h0};
    tab[15] = '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0,        1'b0, 1'b1, 32'h0};
    tab[16] = '{1'b0, 2'd1, 1'b0, 32'h40A, 32'h0,        1'b0, 1'b1, 32'h00008000};
    tab[17] = '{1'b1, 2'd1, 1'b0, 32'h409, 32'h00001234, 1'b1, 1'b0, 32'h0};

    apply_reset();
    wait_fill(1000, fill_cycles);
    chk("fill_cycles", 32'(fill_cycles), 32'd256);
    chk("ready_after_fill", req_ready, 1'b1);

    foreach (tab[i]) begin
      step(1'b1, tab[i].we, tab[i].size, tab[i].sgn, tab[i].addr, tab[i].wdata,
           1'b1, tab[i].exp_err, tab[i].chk_rd, tab[i].exp_rd);
    end
    idle(); idle();

    // Back-to-back store/load on one word: every cycle carries a response.
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      step(1'b1, 1'b1, 2'd2, 1'b0, 32'h410, d, 1'b1, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 2'd2, 1'b0, 32'h410, '0, 1'b1, 1'b0, 1'b1, d);
    end
    idle(); idle();

    for (int i = 0; i < 3000; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       a = BASE - 32'($urandom_range(1, 8));
        1:       a = BASE + 32'(NBYTES) + 32'($urandom_range(0, 8));
        2:       a = BASE + 32'(NBYTES) - 32'($urandom_range(1, 8));
        default: a = BASE + 32'($urandom_range(0, 63));
      endcase
      step($urandom_range(0, 99) < 85, 1'($urandom), sz, 1'($urandom), a, $urandom,
           1'b0, 1'b0, 1'b0, '0);
    end
    idle(); idle();

    // Mid-fill reset: data written beyond the partial fill must still be cleared.
    step(1'b1, 1'b1, 2'd2, 1'b0, 32'h7FC, 32'h5A5A1234, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 2'd2, 1'b0, 32'h404, 32'h0BADF00D, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h7FC, '0, 1'b1, 1'b0, 1'b1, 32'h5A5A1234);
    idle(); idle();
    apply_reset();
    wait_fill(100, fill_cycles);
    chk("busy_at_fill_100", init_busy, 1'b1);
    apply_reset();
    wait_fill(1000, fill_cycles);
    chk("refill_cycles", 32'(fill_cycles), 32'd256);
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h7FC, '0, 1'b1, 1'b0, 1'b1, 32'h0);
    step(1'b1, 1'b0, 2'd2, 1'b0, 32'h404, '0, 1'b1, 1'b0, 1'b1, 32'h0);
    idle(); idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
